sr_drive_seq: RTL and testbench

Serial write sequencer for the SR flip-flop storage cell. It accepts a parallel pattern word and plays it into one SR flip-flop, one bit at a time, LSB first. For each bit it computes the S/R excitation from the flip-flop's fed-back `q` and never issues the forbidden S=R=1 combination. Optionally it reads `q` back after every write and counts mismatches. The block sits between control logic and the flip-flop, and its `s`/`r` outputs connect directly to the flip-flop's `s`/`r` inputs.

---
 rtl/sr_drv_pkg.sv | 27 ++
 rtl/sr_drive_seq_if.sv | 28 ++
 rtl/sr_excite.sv | 27 ++
 rtl/sr_drive_seq.sv | 129 ++++++++++++
 tb/tb_sr_drive_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sr_drv_pkg.sv
// Purpose: shared types and constants for the SR flip-flop write sequencer and cell drivers.
// Latency: none (declarations only).
// Backpressure: n/a.
// Optional feature macro: SR_DRV_CHECK_EN adds the read-back CHECK state to the state enum.
package sr_drv_pkg;

`ifdef SR_DRV_CHECK_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } sr_drv_state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd3
   } sr_drv_state_t;
`endif

   // Excitation codes, ordered {s,r}. 2'b11 is forbidden and deliberately has no name.
   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_RST  = 2'b01;
   localparam logic [1:0] SR_SET  = 2'b10;

endpackage

// File: rtl/sr_drive_seq_if.sv
// Purpose: control + cell-side bundle between control logic, sr_drive_seq and one SR flip-flop.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle (busy=0).
// Ports: start/pattern/q_fb toward the sequencer; s/r/busy/done/err_cnt from it.
// master = control logic + flip-flop side, slave = sequencer.
interface sr_drive_seq_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic             q_fb;
   logic             s;
   logic             r;
   logic             busy;
   logic             done;
   logic [CW-1:0]    err_cnt;

   modport master (
      output start, pattern, q_fb,
      input  s, r, busy, done, err_cnt
   );

   modport slave (
      input  start, pattern, q_fb,
      output s, r, busy, done, err_cnt
   );
endinterface

// File: rtl/sr_excite.sv
// Purpose: combinational SR excitation: drive q toward target t, never emitting s=r=1.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: en (enable, else hold), t (target bit), q (current cell value), s/r (excitation out).
module sr_excite
   import sr_drv_pkg::*;
(
   input  logic en,
   input  logic t,
   input  logic q,
   output logic s,
   output logic r
);

   logic [1:0] sr;

   // Only SR_SET or SR_RST ever leave the hold code, so s&r can never both be 1.
   always_comb begin
      sr = SR_HOLD;
      if (en && (t != q)) begin
         sr = t ? SR_SET : SR_RST;
      end
   end

   assign {s, r} = sr;

endmodule

// File: rtl/sr_drive_seq.sv
// Purpose: plays a parallel pattern LSB-first into one SR flip-flop via its s/r inputs.
// Latency: done in cycle WIDTH+1 after start (2*WIDTH+1 with SR_DRV_CHECK_EN).
// Backpressure: start ignored while busy; caller waits for busy=0 before the next start.
// Ports: clk, rst (sync, active-high); bus (slave modport): start, pattern, q_fb in;
//        s, r, busy, done, err_cnt out.
// Macro: SR_DRV_CHECK_EN adds a read-back CHECK cycle per bit and a live err_cnt.
module sr_drive_seq
   import sr_drv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   sr_drive_seq_if.slave   bus
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   sr_drv_state_t    state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             t_bit;

`ifdef SR_DRV_CHECK_EN
   logic [CW-1:0]    err_q, err_d;
`endif

   assign t_bit = pat_q[idx_q];

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
`ifdef SR_DRV_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d   = bus.pattern;
               idx_d   = '0;
`ifdef SR_DRV_CHECK_EN
               err_d   = '0;
`endif
               state_d = DRIVE;
            end
         end
         DRIVE: begin
`ifdef SR_DRV_CHECK_EN
            state_d = CHECK;
`else
            // Back-to-back bits: q_fb now holds the previous bit's result.
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
`endif
         end
`ifdef SR_DRV_CHECK_EN
         CHECK: begin
            // Cell captured at the end of DRIVE, so q_fb is the written value here.
            if (bus.q_fb != t_bit) begin
               err_d = err_q + 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = DRIVE;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the next-state decode.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SR_DRV_CHECK_EN
         err_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SR_DRV_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   sr_excite u_excite (
      .en (state_q == DRIVE),
      .t  (t_bit),
      .q  (bus.q_fb),
      .s  (bus.s),
      .r  (bus.r)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;
`ifdef SR_DRV_CHECK_EN
   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_drive_seq.sv
// Purpose: self-checking bench for sr_drive_seq with an SR flip-flop model on s/r/q_fb.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_drive_seq;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
`ifdef SR_DRV_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sr_drive_seq_if #(.WIDTH(W), .CW(CW)) bus ();

   sr_drive_seq #(.WIDTH(W), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Ideal SR flip-flop with a preset port; "stuck" forces the read-back to 0.
   logic ff_q = 1'b0;
   logic ff_load = 1'b0;
   logic ff_load_val = 1'b0;
   logic stuck = 1'b0;

   always @(posedge clk) begin
      if (ff_load)                 ff_q <= ff_load_val;
      else if (bus.s && !bus.r)    ff_q <= 1'b1;
      else if (bus.r && !bus.s)    ff_q <= 1'b0;
   end
   assign bus.q_fb = stuck ? 1'b0 : ff_q;

   int n_tests = 0;
   int n_fail  = 0;
   int sr_both = 0;

   always @(negedge clk) begin
      if (bus.s && bus.r) sr_both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full sequence. Cycle c is observed at the negedge following edge c-1
   // (start sampled at edge 0). rst_bit >= 0 aborts with a reset during that bit's DRIVE.
   task automatic run_seq(input string tag, input logic [7:0] pat, input logic init_q,
                          input logic stk, input logic glitch, input int rst_bit);
      logic [7:0] qexp;
      logic       qprev;
      logic       t;
      int         n_err;
      int         exp_done;
      int         di;
      int         pend;

      // Reference: each bit's written value, and mismatches the read-back would see.
      n_err = 0;
      for (int i = 0; i < W; i++) begin
         qexp[i] = stk ? 1'b0 : pat[i];
         if (CHK && (qexp[i] != pat[i])) n_err++;
      end
      exp_done = CHK ? (2 * W + 1) : (W + 1);

      @(negedge clk);
      stuck       = stk;
      ff_load     = 1'b1;
      ff_load_val = init_q;
      @(negedge clk);
      ff_load     = 1'b0;
      qprev       = stk ? 1'b0 : init_q;
      pend        = -1;

      bus.start   = 1'b1;
      bus.pattern = pat;
      @(posedge clk);
      @(negedge clk);
      bus.start   = 1'b0;

      for (int c = 1; c <= exp_done + 1; c++) begin
         if (pend >= 0) begin
            check_eq($sformatf("%s c%0d q_bit%0d", tag, c, pend), 32'(bus.q_fb), 32'(qexp[pend]));
            pend = -1;
         end

         di = -1;
         if (CHK) begin
            if ((c % 2 == 1) && (c < 2 * W + 1)) di = (c - 1) / 2;
         end else if (c <= W) begin
            di = c - 1;
         end

         if (di >= 0) begin
            t = pat[di];
            check_eq($sformatf("%s c%0d sr", tag, c), 32'({bus.s, bus.r}),
                     32'({t & ~qprev, ~t & qprev}));
            qprev = qexp[di];
            pend  = di;
         end else begin
            check_eq($sformatf("%s c%0d sr_idle", tag, c), 32'({bus.s, bus.r}), 32'd0);
         end

         check_eq($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(c <= exp_done));
         check_eq($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(c == exp_done));
         if (c == exp_done) begin
            check_eq($sformatf("%s err_cnt", tag), 32'(bus.err_cnt), 32'(n_err));
         end

         if ((rst_bit >= 0) && (di == rst_bit)) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq({tag, " rst busy"}, 32'(bus.busy), 32'd0);
            check_eq({tag, " rst done"}, 32'(bus.done), 32'd0);
            check_eq({tag, " rst sr"}, 32'({bus.s, bus.r}), 32'd0);
            check_eq({tag, " rst err_cnt"}, 32'(bus.err_cnt), 32'd0);
            stuck = 1'b0;
            return;
         end

         // Mid-sequence start with a different pattern must be ignored.
         if (glitch && (c == 3)) begin
            bus.start   = 1'b1;
            bus.pattern = ~pat;
         end else begin
            bus.start   = 1'b0;
         end
         @(negedge clk);
      end
      stuck = 1'b0;
   endtask

   initial begin
      bus.start   = 1'b1;
      bus.pattern = 8'hC3;
      rst         = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset busy", 32'(bus.busy), 32'd0);
      check_eq("reset done", 32'(bus.done), 32'd0);
      check_eq("reset sr", 32'({bus.s, bus.r}), 32'd0);
      check_eq("reset err_cnt", 32'(bus.err_cnt), 32'd0);
      bus.start = 1'b0;
      rst       = 1'b0;

      run_seq("a5",     8'hA5, 1'b0, 1'b0, 1'b0, -1);
      run_seq("ff",     8'hFF, 1'b1, 1'b0, 1'b0, -1);
      run_seq("stuck",  8'hF0, 1'b0, 1'b1, 1'b0, -1);
      run_seq("glitch", 8'h5A, 1'b1, 1'b0, 1'b1, -1);
      run_seq("rst",    8'h0F, 1'b0, 1'b1, 1'b0, 3);
      run_seq("fresh",  8'h96, 1'b0, 1'b0, 1'b0, -1);
      run_seq("3c",     8'h3C, 1'b1, 1'b0, 1'b0, -1);

      for (int k = 0; k < 10; k++) begin
         run_seq($sformatf("rnd%0d", k), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), -1);
      end

      check_eq("s_and_r_never", 32'(sr_both), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
